// File: rtl/mips_cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
// mips_cpu_muldiv_if : execute-stage <-> multiply/divide unit bus
// Revision 1.0
// ============================================================================
interface mips_cpu_muldiv_if;
   logic        clk_enable;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output clk_enable, start, op, a, b, hi_we, lo_we,
      input  busy, done, hi, lo
   );

   modport slave (
      input  clk_enable, start, op, a, b, hi_we, lo_we,
      output busy, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
`default_nettype none
// ============================================================================
// mips_cpu_muldiv : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional macro MULDIV_FAST_MULT_EN: single-cycle combinational multiply.
// Revision 1.0
// ============================================================================
module mips_cpu_muldiv #(
   parameter int ITERATIONS = 32
) (
   input logic              clk,
   input logic              reset,
   mips_cpu_muldiv_if.slave bus
);
   localparam int CW = $clog2(ITERATIONS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic [1:0]    op_q;
   logic          neg_q;
   logic          neg_r;
   logic          div0;
   logic [31:0]   a_raw;
   logic [31:0]   opnd;
   logic [63:0]   p;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          done_q;

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [64:0] div_shift;
   logic [32:0] div_trial;
   logic [63:0] div_step;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [63:0] mul_init;

   assign is_signed = ~bus.op[0];
   assign a_neg     = is_signed & bus.a[31];
   assign b_neg     = is_signed & bus.b[31];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   // Multiply: P = {acc, multiplier}; add multiplicand into acc on LSB, shift right.
   assign mul_sum  = {1'b0, p[63:32]} + {1'b0, (p[0] ? opnd : 32'd0)};
   assign mul_step = {mul_sum, p[31:1]};

   // Restoring divide: P = {remainder, dividend/quotient}, shift left then trial subtract.
   assign div_shift = {p, 1'b0};
   assign div_trial = div_shift[64:32] - {1'b0, opnd};
   assign div_step  = div_trial[32] ? div_shift[63:0]
                                    : {div_trial[31:0], div_shift[31:1], 1'b1};

   assign prod_fix = neg_q ? -p : p;
   assign quo_fix  = neg_q ? -p[31:0] : p[31:0];
   assign rem_fix  = neg_r ? -p[63:32] : p[63:32];

`ifdef MULDIV_FAST_MULT_EN
   assign mul_init = {32'd0, a_mag} * {32'd0, b_mag};
`else
   assign mul_init = {32'd0, b_mag};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else if (bus.clk_enable) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
`ifdef MULDIV_FAST_MULT_EN
               state_nxt = bus.op[1] ? CALC : FIX;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC:    if (count == CW'(ITERATIONS - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         op_q   <= 2'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         a_raw  <= 32'd0;
         opnd   <= 32'd0;
         p      <= 64'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
      end else if (bus.clk_enable) begin
         done_q <= (state == FIX);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q  <= bus.op;
                  a_raw <= bus.a;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  div0  <= (bus.b == 32'd0);
                  count <= '0;
                  if (bus.op[1]) begin
                     opnd <= b_mag;
                     p    <= {32'd0, a_mag};
                  end else begin
                     opnd <= a_mag;
                     p    <= mul_init;
                  end
               end else begin
                  if (bus.hi_we) hi_q <= bus.a;
                  if (bus.lo_we) lo_q <= bus.a;
               end
            end
            CALC: begin
               count <= count + 1'b1;
               p     <= op_q[1] ? div_step : mul_step;
            end
            FIX: begin
               if (!op_q[1]) begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end else if (div0) begin
                  hi_q <= a_raw;
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
`default_nettype wire
